// File: rtl/stream_pkg.sv
// Shared definitions for the stream demux: route encodings and route FSM states.
package stream_pkg;

    localparam logic ROUTE_OUT0 = 1'b0;
    localparam logic ROUTE_OUT1 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } route_state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer: main register drives the outputs, skid register absorbs
// the beat in flight when downstream stalls. Upstream ready is a registered "skid empty".
module stream_skid_buffer #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_ready;
    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;

    logic w_push;
    logic w_pop;
    logic w_load_main;
    logic w_skid_valid_nxt;

    always_comb begin
        w_push      = i_valid && r_ready;
        w_pop       = r_main_valid && i_ready;
        w_load_main = !r_main_valid || w_pop;
        // A push only reaches the skid entry when main is occupied and not draining.
        w_skid_valid_nxt = r_skid_valid ? !w_load_main : (w_push && !w_load_main);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_ready      <= !w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_load_main) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                end else if (w_push) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= i_data;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/stream_demux_1_2.sv
// Packet-locked 1-to-2 stream demultiplexer; the route is taken from sel on a
// packet's first beat and held until its last beat is accepted.
module stream_demux_1_2
    import stream_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [BUS_WIDTH-1:0] out0_data,
    output logic                 out0_last,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [BUS_WIDTH-1:0] out1_data,
    output logic                 out1_last
);

    route_state_t r_state;
    logic         r_route_q;

    logic             w_route;
    logic             w_accept;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_wr0;
    logic             w_wr1;
    logic [BUS_WIDTH:0] w_in_beat;
    logic [BUS_WIDTH:0] w_out0_beat;
    logic [BUS_WIDTH:0] w_out1_beat;

    always_comb begin
        w_route   = (r_state == ST_IDLE) ? sel : r_route_q;
        // Only the routed buffer gates the input, even if the other one is empty.
        in_ready  = (w_route == ROUTE_OUT1) ? w_rdy1 : w_rdy0;
        w_accept  = in_valid && in_ready;
        w_wr0     = in_valid && (w_route == ROUTE_OUT0);
        w_wr1     = in_valid && (w_route == ROUTE_OUT1);
        w_in_beat = {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_route_q <= ROUTE_OUT0;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: if (!in_last) begin
                    r_state   <= ST_BUSY;
                    r_route_q <= sel;
                end
                ST_BUSY: if (in_last) begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    stream_skid_buffer #(.W(BUS_WIDTH + 1)) u_buf0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_wr0),
        .o_ready (w_rdy0),
        .i_data  (w_in_beat),
        .o_valid (out0_valid),
        .i_ready (out0_ready),
        .o_data  (w_out0_beat)
    );

    stream_skid_buffer #(.W(BUS_WIDTH + 1)) u_buf1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_wr1),
        .o_ready (w_rdy1),
        .i_data  (w_in_beat),
        .o_valid (out1_valid),
        .i_ready (out1_ready),
        .o_data  (w_out1_beat)
    );

    assign out0_last = w_out0_beat[BUS_WIDTH];
    assign out0_data = w_out0_beat[BUS_WIDTH-1:0];
    assign out1_last = w_out1_beat[BUS_WIDTH];
    assign out1_data = w_out1_beat[BUS_WIDTH-1:0];

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed bench for stream_demux_1_2 with hand-computed expectations.
module tb_stream_demux_1_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out0_valid, out0_ready, out0_last;
    logic [31:0] out0_data;
    logic        out1_valid, out1_ready, out1_last;
    logic [31:0] out1_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_demux_1_2 #(.BUS_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic l);
        in_valid = v;
        sel      = s;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        rst_n = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hDEAD, 1'b0);
        #2 rst_n = 1'b0;

        // Reset held with in_valid=1
        step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        check("rel_in_ready_before_edge", in_ready, 0);
        step();
        check("rel_in_ready", in_ready, 1);

        // Packet lock: A1 sel=1, A2 sel=0, A3 sel=1 last
        drive(1'b1, 1'b1, 32'hA1, 1'b0);
        check("lock_ready1", in_ready, 1);
        step();
        check("lock_o1_v1", out1_valid, 1);
        check("lock_o1_d1", out1_data, 32'hA1);
        drive(1'b1, 1'b0, 32'hA2, 1'b0);
        check("lock_ready2", in_ready, 1);
        step();
        check("lock_o1_d2", out1_data, 32'hA2);
        check("lock_o1_l2", out1_last, 0);
        check("lock_o0_v2", out0_valid, 0);
        drive(1'b1, 1'b1, 32'hA3, 1'b1);
        step();
        check("lock_o1_d3", out1_data, 32'hA3);
        check("lock_o1_l3", out1_last, 1);
        check("lock_o0_v3", out0_valid, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("lock_o1_drained", out1_valid, 0);
        check("lock_o0_never", out0_valid, 0);

        // Back-to-back single-beat packets
        drive(1'b1, 1'b0, 32'h10, 1'b1);
        check("b2b_ready0", in_ready, 1);
        step();
        check("b2b_o0_10", out0_data, 32'h10);
        check("b2b_o0_v10", out0_valid, 1);
        drive(1'b1, 1'b1, 32'h11, 1'b1);
        check("b2b_ready1", in_ready, 1);
        step();
        check("b2b_o1_11", out1_data, 32'h11);
        check("b2b_o1_v11", out1_valid, 1);
        check("b2b_o0_gone", out0_valid, 0);
        drive(1'b1, 1'b0, 32'h12, 1'b1);
        check("b2b_ready2", in_ready, 1);
        step();
        check("b2b_o0_12", out0_data, 32'h12);
        check("b2b_o0_v12", out0_valid, 1);
        check("b2b_o1_gone", out1_valid, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();

        // Back-pressure on out0: 4-beat packet B0..B3
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hB0, 1'b0);
        check("bp_ready_b0", in_ready, 1);
        step();
        drive(1'b1, 1'b0, 32'hB1, 1'b0);
        check("bp_ready_b1", in_ready, 1);
        step();
        drive(1'b1, 1'b0, 32'hB2, 1'b0);
        check("bp_full", in_ready, 0);
        check("bp_hold_d0", out0_data, 32'hB0);
        step();
        check("bp_full2", in_ready, 0);
        check("bp_hold_d1", out0_data, 32'hB0);
        check("bp_hold_v", out0_valid, 1);
        out0_ready = 1'b1;
        step();
        check("bp_out_b1", out0_data, 32'hB1);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_out_b2", out0_data, 32'hB2);
        drive(1'b1, 1'b0, 32'hB3, 1'b1);
        step();
        check("bp_out_b3", out0_data, 32'hB3);
        check("bp_last_b3", out0_last, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        check("bp_drained", out0_valid, 0);

        // Head-of-line: out1 stalled with packet in progress, out0 empty
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'hC0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hC1, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hC2, 1'b1);
        check("hol_blocked", in_ready, 0);
        check("hol_o0_empty", out0_valid, 0);
        step();
        check("hol_blocked2", in_ready, 0);
        check("hol_o1_head", out1_data, 32'hC0);
        out1_ready = 1'b1;
        step();
        check("hol_o1_c1", out1_data, 32'hC1);
        check("hol_ready_back", in_ready, 1);
        step();
        check("hol_o1_c2", out1_data, 32'hC2);
        check("hol_o1_last", out1_last, 1);
        check("hol_o0_never", out0_valid, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();

        // Reset mid-packet: D0,D1 of a 4-beat packet to out1, then reset
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 32'hD0, 1'b0);
        step();
        drive(1'b1, 1'b1, 32'hD1, 1'b0);
        step();
        check("mid_o1_valid", out1_valid, 1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_o0", out0_valid, 0);
        check("mid_rst_o1", out1_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hE0, 1'b1);
        check("mid_new_ready", in_ready, 1);
        step();
        check("mid_new_o0_v", out0_valid, 1);
        check("mid_new_o0_d", out0_data, 32'hE0);
        check("mid_new_o1_v", out1_valid, 0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_2.md
# stream_demux_1_2

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on every port. It routes packets from one input stream to one of two output streams. The select is sampled on the first beat of each packet and held until the beat carrying `in_last` is accepted, so a packet is never split across outputs. It is the fan-out counterpart of the 2:1 bus mux and sits where one producer feeds two consumers, for example a DMA write path split between two memory banks. Each output has a two-entry skid buffer, so the block runs at full throughput with no combinational path from `outN_ready` to `in_ready`.

## Interface
- `BUS_WIDTH`, 32, data width of the input and both outputs.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `sel`  input  1  destination of the packet starting on the current beat: 0 = out0, 1 = out1. Ignored on non-first beats.
- `in_valid`  input  1  input beat present.
- `in_ready`  output  1  block accepts the beat this cycle.
- `in_data`  input  BUS_WIDTH  input payload.
- `in_last`  input  1  final beat of the packet.
- `out0_valid` / `out1_valid`  output  1  output beat present.
- `out0_ready` / `out1_ready`  input  1  consumer accepts the beat.
- `out0_data` / `out1_data`  output  BUS_WIDTH  output payload.
- `out0_last` / `out1_last`  output  1  final beat of the packet.

## Operation
- A beat is accepted when `in_valid && in_ready`. An output beat transfers when `outN_valid && outN_ready`.
- Route FSM, 2 states:
  - IDLE: route = `sel`. An accepted beat with `in_last`=0 latches `sel` into `route_q` and moves to BUSY. An accepted beat with `in_last`=1 (single-beat packet) stays in IDLE.
  - BUSY: route = `route_q`, and `sel` is ignored. An accepted beat with `in_last`=1 returns to IDLE. The FSM does not advance on cycles without acceptance.
- `in_ready` = not-full of the routed output's skid buffer only. The routed output being full blocks the input even if the other output is empty. This head-of-line blocking is intended.
- An accepted beat `{in_data, in_last}` is written into the routed output's buffer only. The other buffer is untouched.
- Skid buffer per output:
  - Two entries: main and skid.
  - `ready_up` is registered and equals "skid entry empty".
  - `outN_valid`, `outN_data` and `outN_last` come straight from the main register.
  - Beats leave in arrival order. There is no reordering and no dropping.
- While `outN_valid`=1 and `outN_ready`=0, `outN_data` and `outN_last` are held stable.
- No data is modified. Width is BUS_WIDTH end to end.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - FSM goes to IDLE; `route_q`=0.
  - `out0_valid`=`out1_valid`=0; `out*_data`=0; `out*_last`=0.
  - `in_ready`=0 during reset, and 1 on the first edge after release.
- Latency: a beat accepted at edge N appears on `outN_valid` after edge N (1 cycle).
- Throughput: 1 beat/cycle into an output whose consumer holds ready=1.
- Back-pressure: with `outN_ready`=0, the routed buffer accepts 2 beats, then `in_ready` falls in the following cycle. `in_ready` rises 1 cycle after the first downstream transfer.
- Simultaneous push and pop on the same buffer in one cycle: occupancy is unchanged and both transfers occur.
- A packet switching outputs immediately after `in_last` is allowed with no bubble, provided the new target has space.
- Reset mid-packet: buffered beats are discarded and the FSM returns to IDLE. The next beat is treated as a first beat.

## Structure
- Shared package `stream_pkg`: route encoding constants `ROUTE_OUT0`=0 and `ROUTE_OUT1`=1, plus the FSM state encoding `ST_IDLE` and `ST_BUSY`.
- Sub-module `stream_skid_buffer #(BUS_WIDTH+1)` carries `{last, data}` and is instantiated twice. The top level holds only the FSM, the route mux for `in_ready`, and the write-enable decode.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1. Expect `in_ready`=0 and both `out*_valid`=0. After release, expect `in_ready`=1 next cycle.
- Packet lock: 3-beat packet (0xA1, 0xA2, 0xA3 with last) with `sel`=1 on beat 1 and `sel` toggling on beats 2–3. All three beats must exit out1 in order, and out0 sees nothing.
- Back-to-back single-beat packets 0x10/`sel`=0, 0x11/`sel`=1, 0x12/`sel`=0 on consecutive cycles, both readys=1:
  - out0 gets 0x10, then 0x12.
  - out1 gets 0x11.
  - `in_ready` stays 1 throughout.
- Back-pressure: `out0_ready`=0, stream 4 beats to out0. Expect exactly 2 accepted and `in_ready`=0 after that. Then raise `out0_ready`: expect all 4 beats in order with `out0_data` stable while stalled.
- Head-of-line: out1 full and stalled with a packet in progress to out1. `in_ready` must stay 0 while out0 is empty.
- Reset mid-packet: assert `rst_n`=0 after beat 2 of a 4-beat packet. Expect both outputs invalid. The next packet with `sel`=0 must route to out0.
